// File: rtl/ahb_burst_master.sv
// AHB-Lite INCR burst master: one command -> one pipelined burst; done/err one cycle after final data phase.
// Backpressure: cmd accepted only in IDLE; write beats stall the bus with BUSY; read beats are never stalled.
module ahb_burst_master #(
    parameter int DW     = 32,
    parameter int MAXLEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [31:0]   cmd_addr,
    input  logic [3:0]    cmd_len,
    input  logic [2:0]    cmd_size,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          done,
    output logic          err,
    output logic          hsel,
    output logic [1:0]    htrans,
    output logic [2:0]    hburst,
    output logic [2:0]    hsize,
    output logic          hwrite,
    output logic [31:0]   haddr,
    output logic [DW-1:0] hwdata,
    input  logic          hreadyin,
    input  logic          hresp,
    input  logic [DW-1:0] hrdata
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, ERR} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t      state, state_nxt;
    logic [3:0]  len_r;
    logic [4:0]  a_cnt;
    logic        dp_vld;
    logic        dp_last;
    logic        cmd_acc;
    logic        bad_cmd;
    logic        first_beat;
    logic        last_addr;
    logic        addr_acc;
    logic        in_xfer;
    logic        err_hit;
    logic [31:0] nbytes;
    logic [31:0] last_byte;
    logic [2:0]  burst_code;

    assign cmd_ready = (state == IDLE) && !rst;
    assign cmd_acc   = cmd_valid && cmd_ready;

    // A command whose span leaves its 1KB page, or that is not representable, never touches the bus.
    assign nbytes    = ({28'd0, cmd_len} + 32'd1) << cmd_size;
    assign last_byte = cmd_addr + nbytes - 32'd1;
    assign bad_cmd   = (last_byte[31:10] != cmd_addr[31:10])
                     || ((32'd8 << cmd_size) > 32'(DW))
                     || ({1'b0, cmd_len} >= 5'(MAXLEN));

    always_comb begin
        burst_code = 3'b001;
        case (cmd_len)
            4'd0:    burst_code = 3'b000;
            4'd3:    burst_code = 3'b011;
            4'd7:    burst_code = 3'b101;
            4'd15:   burst_code = 3'b111;
            default: burst_code = 3'b001;
        endcase
    end

    assign first_beat = (a_cnt == 5'd0);
    assign last_addr  = ((a_cnt + 5'd1) == ({1'b0, len_r} + 5'd1));

    // Write beats only go out with data in hand: IDLE before the first beat, BUSY between beats.
    always_comb begin
        htrans = HT_IDLE;
        if (state == BURST) begin
            if (hwrite && !wd_valid)
                htrans = first_beat ? HT_IDLE : HT_BUSY;
            else
                htrans = first_beat ? HT_NONSEQ : HT_SEQ;
        end
    end

    assign hsel     = (htrans != HT_IDLE);
    assign addr_acc = (state == BURST) && htrans[1] && hreadyin;
    assign in_xfer  = (state == BURST) || (state == DRAIN);
    assign err_hit  = in_xfer && hresp && !hreadyin;

    assign wd_ready = addr_acc && hwrite;
    assign rd_valid = in_xfer && dp_vld && !hwrite && hreadyin && !hresp;
    assign rd_data  = rd_valid ? hrdata : '0;
    assign rd_last  = rd_valid && dp_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_acc && !bad_cmd) state_nxt = BURST;
            BURST: begin
                if (err_hit)                    state_nxt = ERR;
                else if (addr_acc && last_addr) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (err_hit)                    state_nxt = ERR;
                else if (dp_vld && hreadyin)    state_nxt = IDLE;
            end
            ERR:   if (hreadyin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haddr   <= '0;
            hburst  <= '0;
            hsize   <= '0;
            hwrite  <= 1'b0;
            hwdata  <= '0;
            len_r   <= '0;
            a_cnt   <= '0;
            dp_vld  <= 1'b0;
            dp_last <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (cmd_acc) begin
                if (bad_cmd) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end else begin
                    haddr  <= cmd_addr;
                    hburst <= burst_code;
                    hsize  <= cmd_size;
                    hwrite <= cmd_write;
                    len_r  <= cmd_len;
                    a_cnt  <= '0;
                end
                dp_vld <= 1'b0;
            end else if (addr_acc) begin
                haddr   <= haddr + (32'd1 << hsize);
                a_cnt   <= a_cnt + 5'd1;
                dp_vld  <= 1'b1;
                dp_last <= last_addr;
                if (hwrite)
                    hwdata <= wd_data;
            end else if (dp_vld && hreadyin) begin
                dp_vld <= 1'b0;
            end
            if (state == DRAIN && dp_vld && hreadyin)
                done <= 1'b1;
            if (state == ERR && hreadyin) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: inputs change 1ns after the rising edge, outputs checked 1ns later.
module tb_ahb_burst_master;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [31:0]   cmd_addr;
    logic [3:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid, rd_last, done, err;
    logic [DW-1:0] rd_data;
    logic          hsel, hwrite;
    logic [1:0]    htrans;
    logic [2:0]    hburst, hsize;
    logic [31:0]   haddr;
    logic [DW-1:0] hwdata;
    logic          hreadyin, hresp;
    logic [DW-1:0] hrdata;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ahb_burst_master #(.DW(DW), .MAXLEN(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .hsel(hsel), .htrans(htrans), .hburst(hburst), .hsize(hsize),
        .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .hreadyin(hreadyin), .hresp(hresp), .hrdata(hrdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = 3'd2;
        #1;
        chk("cmd_ready_before_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int beat;
        int gap;
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
        wd_valid = 0; wd_data = 0; hreadyin = 1; hresp = 0; hrdata = 0;

        // Reset values
        repeat (3) tick();
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_hsel", hsel, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_hburst", hburst, 0);
        chk("rst_outs", {wd_ready, rd_valid, rd_last, done, err}, 5'b0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);
        tick();

        // Single write at 0x100
        wd_valid = 1'b1;
        wd_data  = 32'hA5A5A5A5;
        issue(1'b1, 32'h100, 4'd0);
        #1;
        chk("t1_htrans_nonseq", htrans, 2'b10);
        chk("t1_hburst_single", hburst, 3'b000);
        chk("t1_haddr", haddr, 32'h100);
        chk("t1_hsel", hsel, 1);
        chk("t1_wd_ready", wd_ready, 1);
        tick();
        wd_valid = 1'b0;
        #1;
        chk("t1_hwdata", hwdata, 32'hA5A5A5A5);
        chk("t1_htrans_idle", htrans, 2'b00);
        chk("t1_done_early", done, 0);
        tick();
        #1;
        chk("t1_done", {done, err}, 2'b10);
        chk("t1_cmd_ready_on_done", cmd_ready, 1);
        tick();
        #1;
        chk("t1_done_one_cycle", done, 0);

        // INCR4 read at 0x200, wait state while 0x208 is in address phase
        issue(1'b0, 32'h200, 4'd3);
        #1;
        chk("t2_htrans_nonseq", htrans, 2'b10);
        chk("t2_hburst_incr4", hburst, 3'b011);
        chk("t2_haddr0", haddr, 32'h200);
        chk("t2_no_rd_first", rd_valid, 0);
        tick();
        hrdata = 32'h11110000;
        #1;
        chk("t2_haddr1", {htrans, haddr}, {2'b11, 32'h204});
        chk("t2_rd0", {rd_valid, rd_last, rd_data}, {2'b10, 32'h11110000});
        tick();
        hreadyin = 1'b0;
        hrdata   = 32'h22220000;
        #1;
        chk("t2_haddr2_a", haddr, 32'h208);
        chk("t2_wait_no_rd", rd_valid, 0);
        tick();
        hreadyin = 1'b1;
        #1;
        chk("t2_haddr2_held", {htrans, haddr}, {2'b11, 32'h208});
        chk("t2_rd1", {rd_valid, rd_last, rd_data}, {2'b10, 32'h22220000});
        tick();
        hrdata = 32'h33330000;
        #1;
        chk("t2_haddr3", haddr, 32'h20C);
        chk("t2_rd2", {rd_valid, rd_last, rd_data}, {2'b10, 32'h33330000});
        tick();
        hrdata = 32'h44440000;
        #1;
        chk("t2_drain_idle", htrans, 2'b00);
        chk("t2_rd3_last", {rd_valid, rd_last, rd_data}, {2'b11, 32'h44440000});
        tick();
        #1;
        chk("t2_done", {done, err, rd_valid}, 3'b100);
        tick();

        // INCR8 write at 0x300, write data withheld for two cycles before the fourth beat
        wd_valid = 1'b1;
        wd_data  = 32'hC0DE0000;
        issue(1'b1, 32'h300, 4'd7);
        beat = 0;
        gap  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            wd_valid = !(beat == 3 && gap < 2);
            wd_data  = 32'hC0DE0000 + 32'(beat);
            #1;
            if (done) break;
            if (!wd_valid) begin
                chk("t3_busy", {htrans, haddr}, {2'b01, 32'h30C});
                gap++;
            end
            if (wd_ready) begin
                chk("t3_beat_addr", {htrans, haddr},
                    {(beat == 0) ? 2'b10 : 2'b11, 32'h300 + 32'(4 * beat)});
                chk("t3_hburst", hburst, 3'b101);
                beat++;
            end
            tick();
        end
        wd_valid = 1'b0;
        chk("t3_beats", beat, 8);
        chk("t3_busy_cycles", gap, 2);
        chk("t3_done", {done, err}, 2'b10);
        chk("t3_last_hwdata", hwdata, 32'hC0DE0007);
        tick();

        // Read crossing a 1KB page: no transfer, immediate error completion
        issue(1'b0, 32'h3F8, 4'd5);
        #1;
        chk("t4_no_xfer", {hsel, htrans}, 3'b000);
        chk("t4_done_err", {done, err}, 2'b11);
        tick();
        #1;
        chk("t4_still_idle", {htrans, done}, 3'b000);

        // INCR4 read with ERROR response on the second data phase
        issue(1'b0, 32'h200, 4'd3);
        tick();
        hrdata = 32'h55550000;
        #1;
        chk("t5_rd0", {rd_valid, rd_data}, {1'b1, 32'h55550000});
        tick();
        hreadyin = 1'b0;
        hresp    = 1'b1;
        #1;
        chk("t5_err1_rd", rd_valid, 0);
        chk("t5_err1_htrans", htrans, 2'b11);
        tick();
        hreadyin = 1'b1;
        #1;
        chk("t5_err2_htrans_idle", htrans, 2'b00);
        chk("t5_err2_rd", {rd_valid, done}, 2'b00);
        tick();
        hresp = 1'b0;
        #1;
        chk("t5_done_err", {done, err}, 2'b11);
        chk("t5_after_idle", {htrans, rd_valid}, 3'b000);
        tick();

        // Reset during third beat of an INCR16 read
        issue(1'b0, 32'h0, 4'd15);
        #1;
        chk("t6_hburst_incr16", hburst, 3'b111);
        tick();
        tick();
        hrdata = 32'h66660000;
        rst = 1'b1;
        #1;
        chk("t6_rst_bus", {hsel, htrans, hburst, hsize, hwrite}, 12'b0);
        chk("t6_rst_haddr", haddr, 0);
        chk("t6_rst_hwdata", hwdata, 0);
        chk("t6_rst_outs", {cmd_ready, wd_ready, rd_valid, rd_last, done, err}, 6'b0);
        chk("t6_rst_rd_data", rd_data, 0);
        tick();
        #1;
        chk("t6_rst_hold", {cmd_ready, htrans, rd_valid, done}, 5'b0);
        rst = 1'b0;
        #1;
        chk("t6_cmd_ready_after_rst", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("t6_no_done", {done, htrans}, 3'b000);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ahb_burst_master.md
AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 Parameter DW, default 32, meaning data width in bits (32 or 64).
REQ-002 Parameter MAXLEN, default 16, meaning maximum beats per command (power of two, at most 16).
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake; a command is accepted when both are high.
REQ-006 cmd_write  in  1  1=write, 0=read.
REQ-007 cmd_addr  in  32  start byte address.
REQ-008 cmd_len  in  4  beats minus 1.
REQ-009 cmd_size  in  3  HSIZE code; only values with (8<<cmd_size) <= DW are legal.
REQ-010 wd_valid/wd_ready/wd_data  in/out/in  1/1/DW  write-beat stream; a beat is consumed when wd_valid and wd_ready are both high.
REQ-011 rd_valid/rd_data/rd_last  out/out/out  1/DW/1  read-beat stream, no backpressure.
REQ-012 done/err  out/out  1/1  one-cycle completion pulse; err is qualified by done.
REQ-013 hsel, htrans[1:0], hburst[2:0], hsize[2:0], hwrite, haddr[31:0], hwdata[DW-1:0]  out  AHB master outputs.
REQ-014 hreadyin, hresp, hrdata[DW-1:0]  in  AHB slave responses.

Function
REQ-015 States SHALL be IDLE, BURST, DRAIN and ERR.
- IDLE->BURST on command accept.
- BURST->DRAIN when the last address phase is accepted (htrans!=IDLE, hreadyin=1).
- DRAIN->IDLE when the last data phase completes with hreadyin=1.
- Any state->ERR on hresp=1 with hreadyin=0.
- ERR->IDLE on hreadyin=1.
REQ-016 cmd_ready SHALL be high only in IDLE; command fields are registered on accept.
REQ-017 hburst SHALL be:
- SINGLE (000) for len 0;
- INCR4 (011) for len 3;
- INCR8 (101) for len 7;
- INCR16 (111) for len 15;
- INCR (001) otherwise.
REQ-018 The first beat SHALL drive htrans=NONSEQ (10). Subsequent beats SHALL drive SEQ (11). IDLE (00) is driven outside BURST.
REQ-019 haddr SHALL start at cmd_addr and increment by (1<<cmd_size) on each accepted address phase; it is held while hreadyin=0.
REQ-020 hsel SHALL equal (htrans!=IDLE). hsize, hwrite and hburst are held constant for the whole burst.
REQ-021 The data phase of beat n SHALL overlap the address phase of beat n+1 (pipelined, zero bubble when hreadyin=1).
REQ-022 Write path:
- wd_ready SHALL pulse for one beat when that beat's address phase is accepted.
- wd_data is registered into hwdata and held until its data phase completes with hreadyin=1.
REQ-023 If a write beat is due and wd_valid=0 in BURST, the block SHALL drive htrans=BUSY (01) with haddr held, and resume with SEQ once wd_valid=1.
- BUSY SHALL never be the first or the last beat.
- The first beat is not issued until wd_valid=1.
REQ-024 Read path: rd_valid SHALL be high for exactly one cycle per completed read data phase (hreadyin=1, hresp=0). rd_data equals hrdata in that cycle, and rd_last marks beat cmd_len.
REQ-025 Beat counting SHALL use a 5-bit counter compared against cmd_len+1; no modulo wrap inside a burst.
REQ-026 1KB rule: a command whose last byte address lies in a different 1KB page than cmd_addr SHALL NOT issue any bus transfer, and SHALL produce done=1, err=1 one cycle after acceptance.
REQ-027 On the first ERROR cycle, the block SHALL drive htrans=IDLE from the next cycle onward, cancelling the pending address.
- No further rd_valid or wd_ready is produced.
- done=1, err=1 fires in the cycle after the second ERROR cycle.
REQ-028 Normal completion SHALL pulse done=1, err=0 in the cycle after the final data phase.
REQ-029 A new command SHALL be acceptable in the cycle done is high.

Reset
REQ-030 While rst=1 the block SHALL:
- be in state IDLE;
- drive cmd_ready=0;
- drive htrans=00, hsel=0, hburst=000, hsize=000, hwrite=0, haddr=0, hwdata=0;
- drive wd_ready=0, rd_valid=0, rd_data=0, rd_last=0, done=0, err=0.
REQ-031 cmd_ready SHALL rise in the first clock cycle after rst falls.
REQ-032 Reset asserted mid-burst SHALL abandon the burst immediately, with no done pulse.

Verification
REQ-033 Single write, addr=0x100, len=0, size=2, wd_data=0xA5A5A5A5, hreadyin=1 -> expected response:
- htrans NONSEQ, hburst SINGLE, haddr 0x100;
- hwdata 0xA5A5A5A5 in the next cycle;
- done=1, err=0 one cycle later.
REQ-034 INCR4 read, addr=0x200, len=3, size=2, one wait state on beat 2 -> expected response:
- haddr 0x200, 0x204, 0x208, 0x20C, with 0x208 held for two cycles;
- four rd_valid pulses, with rd_last on the fourth.
REQ-035 INCR8 write, with wd_valid deasserted for 2 cycles before beat 4 -> expected response:
- htrans=BUSY for 2 cycles, haddr held;
- then SEQ; 8 beats total, done=1.
REQ-036 Read len=5 at 0x3F8, size=2 -> expected response: 1KB crossing, no htrans!=IDLE, done=1, err=1 one cycle after accept.
REQ-037 INCR4 read with hresp=1 on beat 2 (two-cycle ERROR) -> expected response:
- htrans=IDLE from the cycle after the first ERROR cycle;
- only 1 rd_valid;
- done=1, err=1.
REQ-038 rst asserted during beat 3 of INCR16 -> expected response:
- all outputs at reset values while rst=1;
- cmd_ready=1 in the first cycle after rst falls;
- no done pulse.
